// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: fifo_sync registered-read port -> valid/ready burst stream, m_valid 2 cycles after fifo_re.
// m_ready stalls hold m_data and withhold read credits; FIFO_RD_STATS_EN adds saturating word/stall counters.
module fifo_rd_stream #(
  parameter int WIDTH     = 32,
  parameter int BURST_LEN = 8,
  parameter int STAT_W    = 16,
  localparam int BW       = $clog2(BURST_LEN + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              fifo_empty_i,
  input  logic [WIDTH-1:0]  fifo_rdata_i,
  output logic              fifo_re_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [WIDTH-1:0]  m_data_o,
  output logic              m_last_o,
  output logic [BW-1:0]     beat_cnt_o
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_words_o,
  output logic [STAT_W-1:0] stat_stalls_o
`endif
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;

  state_e           state_q, state_d;
  logic             inflight_q;
  logic             head_q, head_d;
  logic [WIDTH-1:0] ent_q [2];
  logic [BW-1:0]    beat_q, beat_d;
  logic             pop;
  logic             capture;
  logic             wr_idx;
  logic [2:0]       credit;
  logic             beat_wrap;

  assign m_valid_o = (state_q != EMPTY) && !flush_i;
  assign pop       = m_valid_o && m_ready_i;
  assign capture   = inflight_q && !flush_i;

  // Counting the current pop as a returned credit keeps one read per cycle under m_ready=1.
  assign credit    = {1'b0, state_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign fifo_re_o = rst_ni && !fifo_empty_i && !flush_i && (credit < 3'd2);

  assign wr_idx     = head_q ^ (state_q == ONE);
  assign m_data_o   = ent_q[head_q];
  assign beat_wrap  = (beat_q == BW'(BURST_LEN - 1));
  assign m_last_o   = m_valid_o && beat_wrap;
  assign beat_cnt_o = beat_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    beat_d  = beat_q;
    if (flush_i) begin
      state_d = EMPTY;
      beat_d  = '0;
    end else begin
      if (pop) begin
        head_d = ~head_q;
        beat_d = beat_wrap ? '0 : beat_q + 1'b1;
      end
      case (state_q)
        EMPTY:   if (capture) state_d = ONE;
        ONE: begin
          if (capture && !pop)      state_d = TWO;
          else if (!capture && pop) state_d = EMPTY;
        end
        TWO:     if (pop) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= EMPTY;
      inflight_q <= 1'b0;
      head_q     <= 1'b0;
      beat_q     <= '0;
      ent_q[0]   <= '0;
      ent_q[1]   <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_re_o;
      head_q     <= head_d;
      beat_q     <= beat_d;
      if (capture) ent_q[wr_idx] <= fifo_rdata_i;
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                  !(capture && state_q == TWO));

`ifdef FIFO_RD_STATS_EN
  logic [STAT_W-1:0] words_q, stalls_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      words_q  <= '0;
      stalls_q <= '0;
    end else begin
      if (pop && (words_q != '1)) words_q <= words_q + 1'b1;
      if (m_valid_o && !m_ready_i && (stalls_q != '1)) stalls_q <= stalls_q + 1'b1;
    end
  end

  assign stat_words_o  = words_q;
  assign stat_stalls_o = stalls_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: a BURST_LEN=8 instance driven by a vector table plus
// hand sequences for reset mid-burst, and a BURST_LEN=1 instance for single-word bursts.
module tb_fifo_rd_stream;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  logic         flush_a, empty_a, re_a, vld_a, rdy_a, last_a;
  logic [W-1:0] rdata_a, data_a;
  logic [3:0]   beat_a;
  logic         flush_b, empty_b, re_b, vld_b, rdy_b, last_b;
  logic [W-1:0] rdata_b, data_b;
  logic [0:0]   beat_b;
`ifdef FIFO_RD_STATS_EN
  logic [15:0]  sw_a, ss_a;
  logic [3:0]   sw_b, ss_b;
`endif

  fifo_rd_stream #(.WIDTH(W), .BURST_LEN(8)) u_a (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_a), .fifo_empty_i(empty_a),
    .fifo_rdata_i(rdata_a), .fifo_re_o(re_a), .m_valid_o(vld_a), .m_ready_i(rdy_a),
    .m_data_o(data_a), .m_last_o(last_a), .beat_cnt_o(beat_a)
`ifdef FIFO_RD_STATS_EN
    , .stat_words_o(sw_a), .stat_stalls_o(ss_a)
`endif
  );

  fifo_rd_stream #(.WIDTH(W), .BURST_LEN(1), .STAT_W(4)) u_b (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_b), .fifo_empty_i(empty_b),
    .fifo_rdata_i(rdata_b), .fifo_re_o(re_b), .m_valid_o(vld_b), .m_ready_i(rdy_b),
    .m_data_o(data_b), .m_last_o(last_b), .beat_cnt_o(beat_b)
`ifdef FIFO_RD_STATS_EN
    , .stat_words_o(sw_b), .stat_stalls_o(ss_b)
`endif
  );

  typedef struct {
    bit rdy; bit fl; int push;
    bit vld; int dat; bit last; int beat; bit re;
  } vec_t;

  vec_t         tbl[$];
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  int           nxt_a = 0;
  int           errors = 0;
  int           checks = 0;

  function automatic void add(input bit rdy, input bit fl, input int push, input bit vld,
                              input int dat, input bit last, input int beat, input bit re);
    vec_t v;
    v.rdy = rdy; v.fl = fl; v.push = push; v.vld = vld;
    v.dat = dat; v.last = last; v.beat = beat; v.re = re;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for m_valid", name);
  endtask

  // FIFO model: read data appears the cycle after a sampled fifo_re.
  task automatic cyc();
    logic sa, sb;
    sa = re_a;
    sb = re_b;
    @(posedge clk);
    #1;
    if (sa && qa.size() > 0) rdata_a = qa.pop_front();
    if (sb && qb.size() > 0) rdata_b = qb.pop_front();
    empty_a = (qa.size() == 0);
    empty_b = (qb.size() == 0);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int nb;
    rst_ni = 1'b1; flush_a = 1'b0; flush_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
    empty_a = 1'b1; empty_b = 1'b1; rdata_a = '0; rdata_b = '0;

    // Test 1: 16 preloaded words, m_ready=1, bursts of 8.
    for (int k = 0; k < 19; k++) begin
      bit v;
      v = (k >= 2) && (k <= 17);
      add(1, 0, (k == 0) ? 16 : 0, v, v ? k - 2 : 0, v && ((k - 2) % 8 == 7),
          v ? (k - 2) % 8 : 0, k <= 15);
    end
    // Test 2: m_ready 1,0,0,1 stall with credits exhausted.
    add(1,0,8,0, 0,0,0,1); add(1,0,0,0, 0,0,0,1); add(1,0,0,1,16,0,0,1);
    add(0,0,0,1,17,0,1,0); add(0,0,0,1,17,0,1,0); add(1,0,0,1,17,0,1,1);
    add(1,0,0,1,18,0,2,1); add(1,0,0,1,19,0,3,1); add(1,0,0,1,20,0,4,1);
    add(1,0,0,1,21,0,5,1); add(1,0,0,1,22,0,6,0); add(1,0,0,1,23,1,7,0);
    add(1,0,0,0, 0,0,0,0);
    // Test 3: flush with word 24 buffered and 25 being captured; 26 follows at beat 0.
    add(1,0,8,0, 0,0,0,1); add(1,0,0,0, 0,0,0,1); add(1,1,0,0, 0,0,0,0);
    add(1,0,0,0, 0,0,0,1); add(1,0,0,0, 0,0,0,1); add(1,0,0,1,26,0,0,1);
    add(1,0,0,1,27,0,1,1); add(1,0,0,1,28,0,2,1); add(1,0,0,1,29,0,3,1);
    add(1,0,0,1,30,0,4,0); add(0,0,0,1,31,0,5,0);

    #2 rst_ni = 1'b0;
    empty_a = 1'b0;
    #1;
    chk("rst fifo_re", re_a, 0);
    chk("rst m_valid", vld_a, 0);
    chk("rst m_data", data_a, 0);
    chk("rst m_last", last_a, 0);
    chk("rst beat_cnt", beat_a, 0);
    empty_a = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    #1;

    foreach (tbl[i]) begin
      for (int p = 0; p < tbl[i].push; p++) begin
        qa.push_back(nxt_a);
        nxt_a++;
      end
      empty_a = (qa.size() == 0);
      rdy_a   = tbl[i].rdy;
      flush_a = tbl[i].fl;
      #1;
      chk($sformatf("row%0d m_valid", i), vld_a, tbl[i].vld);
      chk($sformatf("row%0d m_last", i), last_a, tbl[i].last);
      chk($sformatf("row%0d beat_cnt", i), beat_a, tbl[i].beat);
      chk($sformatf("row%0d fifo_re", i), re_a, tbl[i].re);
      if (tbl[i].vld) chk($sformatf("row%0d m_data", i), data_a, tbl[i].dat);
      cyc();
    end
    flush_a = 1'b0;

    // Test 4: async reset while word 31 waits at beat 5.
    chk("t4 pre m_valid", vld_a, 1);
    chk("t4 pre beat_cnt", beat_a, 5);
    rst_ni = 1'b0;
    #1;
    chk("t4 m_valid", vld_a, 0);
    chk("t4 m_data", data_a, 0);
    chk("t4 m_last", last_a, 0);
    chk("t4 beat_cnt", beat_a, 0);
    chk("t4 fifo_re", re_a, 0);
    cyc();
    rst_ni = 1'b1;
    for (int p = 0; p < 3; p++) begin
      qa.push_back(nxt_a);
      nxt_a++;
    end
    empty_a = 1'b0;
    rdy_a   = 1'b1;
    #1;
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      if (vld_a) begin
        got = 1'b1;
        chk("t4 first data", data_a, 32);
        chk("t4 first beat", beat_a, 0);
      end else begin
        cyc();
      end
    end
    if (!got) timeout("t4 first word");

    // Test 5: BURST_LEN=1 marks every beat as last.
    for (int p = 0; p < 3; p++) qb.push_back(100 + p);
    empty_b = 1'b0;
    rdy_b   = 1'b1;
    #1;
    nb = 0;
    for (int n = 0; n < 10; n++) begin
      if (vld_b) begin
        chk($sformatf("t5 last beat%0d", nb), last_b, 1);
        chk($sformatf("t5 data beat%0d", nb), data_b, 100 + nb);
        chk($sformatf("t5 cnt beat%0d", nb), beat_b, 0);
        nb++;
      end
      cyc();
    end
    chk("t5 beats", nb, 3);

`ifdef FIFO_RD_STATS_EN
    // Test 6: 20 total pops saturate a 4-bit counter; exactly 3 stall cycles.
    for (int p = 0; p < 17; p++) qb.push_back(200 + p);
    empty_b = 1'b0;
    rdy_b   = 1'b0;
    #1;
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      if (vld_b) got = 1'b1;
      else cyc();
    end
    if (!got) timeout("t6 first word");
    repeat (3) cyc();
    rdy_b = 1'b1;
    repeat (25) cyc();
    chk("t6 stat_words", sw_b, 15);
    chk("t6 stat_stalls", ss_b, 3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
